// File: rtl/reg_file_arbiter_pkg.sv
// reg_file_arb_pkg: shared constants for the register-file arbiter.
//   - FSM state encoding (2-bit, legacy-compatible localparams)
//   - requester IDs (REQ_A / REQ_B)
//   - default read-valid watchdog limit
package reg_file_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 8;

endpackage

// File: rtl/reg_file_arbiter_if.sv
// reg_file_arbiter_if: bundles both requester ports and the register-file
// port of the arbiter.
//   slave  : arbiter side (takes requests, drives the register file)
//   master : environment side (requesters + register file)
//
// Handshake: a requester raises xREQ with xWR/xADDR/xWDATA stable and holds
// it until it sees the one-cycle xDONE pulse, then drops xREQ on that edge.
// xRDATA/xERR are meaningful only while xDONE=1. Towards the register file,
// RF_R_EN/RF_W_EN are single-cycle strobes; a read completes when the file
// raises RF_RD_VALID with RF_RDATA (there is no back-pressure on either side).
interface reg_file_arbiter_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_BITS = 4
);
    logic                    A_REQ;
    logic                    A_WR;
    logic [ADDRESS_BITS-1:0] A_ADDR;
    logic [DATA_WIDTH-1:0]   A_WDATA;
    logic [DATA_WIDTH-1:0]   A_RDATA;
    logic                    A_DONE;
    logic                    A_ERR;

    logic                    B_REQ;
    logic                    B_WR;
    logic [ADDRESS_BITS-1:0] B_ADDR;
    logic [DATA_WIDTH-1:0]   B_WDATA;
    logic [DATA_WIDTH-1:0]   B_RDATA;
    logic                    B_DONE;
    logic                    B_ERR;

    logic                    RF_R_EN;
    logic                    RF_W_EN;
    logic [ADDRESS_BITS-1:0] RF_ADDR;
    logic [DATA_WIDTH-1:0]   RF_WDATA;
    logic [DATA_WIDTH-1:0]   RF_RDATA;
    logic                    RF_RD_VALID;

    logic                    BUSY;

    modport slave (
        input  A_REQ, A_WR, A_ADDR, A_WDATA,
        output A_RDATA, A_DONE, A_ERR,
        input  B_REQ, B_WR, B_ADDR, B_WDATA,
        output B_RDATA, B_DONE, B_ERR,
        output RF_R_EN, RF_W_EN, RF_ADDR, RF_WDATA,
        input  RF_RDATA, RF_RD_VALID,
        output BUSY
    );

    modport master (
        output A_REQ, A_WR, A_ADDR, A_WDATA,
        input  A_RDATA, A_DONE, A_ERR,
        output B_REQ, B_WR, B_ADDR, B_WDATA,
        input  B_RDATA, B_DONE, B_ERR,
        input  RF_R_EN, RF_W_EN, RF_ADDR, RF_WDATA,
        output RF_RDATA, RF_RD_VALID,
        input  BUSY
    );

endinterface

// File: rtl/reg_file_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with a last-served pointer.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> REQ_B)
//   req_a/b   : request inputs
//   update    : load the pointer with the current grant
//   grant     : at least one request present
//   grant_id  : winning requester (REQ_A / REQ_B)
//   last_srv  : current pointer value
module rr_arb2
    import reg_file_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic grant,
    output logic grant_id,
    output logic last_srv
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req_a | req_b;
        if (req_a && req_b) begin
            // Tie: whoever was not served last wins.
            grant_id = (last_q == REQ_B) ? REQ_A : REQ_B;
        end else if (req_a) begin
            grant_id = REQ_A;
        end else begin
            grant_id = REQ_B;
        end
        last_d = update ? grant_id : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_srv = last_q;

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares one register file between requesters A and B.
// One command at a time is latched in IDLE, issued for a single cycle in
// ISSUE, completed in WAIT_RD for reads, and acknowledged with a one-cycle
// xDONE in RESP. All outputs are registered.
//   CLK, RST  : clock, asynchronous active-high reset
//   bus       : requester A/B ports, register-file port and BUSY
//   dbg_state : current FSM state (ST_* encoding)
// Optional macro RD_TIMEOUT_EN: adds a read-valid watchdog of TIMEOUT_CYCLES
// cycles in WAIT_RD that completes the read with xRDATA=0 and xERR=1.
module reg_file_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_BITS   = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               CLK,
    input  logic               RST,
    reg_file_arbiter_if.slave  bus,
    output logic [1:0]         dbg_state
);

    logic [1:0]              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    wr_q, wr_d;
    logic                    rf_r_en_q, rf_r_en_d;
    logic                    rf_w_en_q, rf_w_en_d;
    logic [ADDRESS_BITS-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;
    logic                    a_done_q, a_done_d;
    logic                    b_done_q, b_done_d;
    logic                    busy_q, busy_d;

    logic grant, grant_id, arb_update, last_srv;

`ifdef RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          a_err_q, a_err_d;
    logic          b_err_q, b_err_d;
`endif

    rr_arb2 u_arb (
        .clk      (CLK),
        .rst      (RST),
        .req_a    (bus.A_REQ),
        .req_b    (bus.B_REQ),
        .update   (arb_update),
        .grant    (grant),
        .grant_id (grant_id),
        .last_srv (last_srv)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        rf_r_en_d  = 1'b0;
        rf_w_en_d  = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        arb_update = 1'b0;
`ifdef RD_TIMEOUT_EN
        tmo_cnt_d  = '0;
        a_err_d    = 1'b0;
        b_err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    // Enables and address are registered here so they are on
                    // the register-file port for exactly the ISSUE cycle.
                    owner_d    = grant_id;
                    wr_d       = (grant_id == REQ_B) ? bus.B_WR    : bus.A_WR;
                    rf_addr_d  = (grant_id == REQ_B) ? bus.B_ADDR  : bus.A_ADDR;
                    rf_wdata_d = (grant_id == REQ_B) ? bus.B_WDATA : bus.A_WDATA;
                    rf_w_en_d  = wr_d;
                    rf_r_en_d  = !wr_d;
                    arb_update = bus.A_REQ && bus.B_REQ;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d  = ST_RESP;
                    a_done_d = (owner_q == REQ_A);
                    b_done_d = (owner_q == REQ_B);
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (bus.RF_RD_VALID) begin
                    state_d  = ST_RESP;
                    a_done_d = (owner_q == REQ_A);
                    b_done_d = (owner_q == REQ_B);
                    if (owner_q == REQ_A) a_rdata_d = bus.RF_RDATA;
                    else                  b_rdata_d = bus.RF_RDATA;
                end
`ifdef RD_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Last allowed WAIT_RD cycle without valid: give up.
                    state_d  = ST_RESP;
                    a_done_d = (owner_q == REQ_A);
                    b_done_d = (owner_q == REQ_B);
                    a_err_d  = (owner_q == REQ_A);
                    b_err_d  = (owner_q == REQ_B);
                    if (owner_q == REQ_A) a_rdata_d = '0;
                    else                  b_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_A;
            wr_q       <= 1'b0;
            rf_r_en_q  <= 1'b0;
            rf_w_en_q  <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef RD_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            rf_r_en_q  <= rf_r_en_d;
            rf_w_en_q  <= rf_w_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            busy_q     <= busy_d;
`ifdef RD_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
`endif
        end
    end

    assign bus.RF_R_EN  = rf_r_en_q;
    assign bus.RF_W_EN  = rf_w_en_q;
    assign bus.RF_ADDR  = rf_addr_q;
    assign bus.RF_WDATA = rf_wdata_q;
    assign bus.A_RDATA  = a_rdata_q;
    assign bus.B_RDATA  = b_rdata_q;
    assign bus.A_DONE   = a_done_q;
    assign bus.B_DONE   = b_done_q;
    assign bus.BUSY     = busy_q;
    assign dbg_state    = state_q;
`ifdef RD_TIMEOUT_EN
    assign bus.A_ERR    = a_err_q;
    assign bus.B_ERR    = b_err_q;
`else
    assign bus.A_ERR    = 1'b0;
    assign bus.B_ERR    = 1'b0;
`endif

endmodule
